shift_seq_ctrl: RTL and testbench

Frame sequencer that drives the serial input of the team's 4-bit shift_register datapath (and wider variants). It accepts parallel words over a valid/ready handshake and emits each word as a timed serial frame: start bit, data LSB first, optional even parity, stop bit. A per-bit strobe tells the downstream shift register when to sample. This lets upstream logic load words without knowing the bit timing.

---
 rtl/shift_seq_pkg.sv | 26 ++
 rtl/shift_seq_ctrl_bit_timer.sv | 43 ++++
 rtl/shift_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_shift_seq_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared definitions for the serial frame sequencer.
//   state_t     : frame sequencer states
//   *_LVL       : serial line levels for idle, start and stop bits
//   frame_bits  : number of bit periods in one frame
package shift_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Idle and stop share level 0 so a downstream register that resets to 0
  // sees no spurious edge; the start bit is the only 1 that frames a word.
  localparam logic START_LVL = 1'b1;
  localparam logic STOP_LVL  = 1'b0;
  localparam logic IDLE_LVL  = 1'b0;

  function automatic int unsigned frame_bits(input int unsigned width,
                                             input bit          parity_en);
    return width + 32'd2 + (parity_en ? 32'd1 : 32'd0);
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_bit_timer.sv
// Bit-period timer: counts 0..DIV-1 and flags the last cycle of each period.
//   clk, reset : clock, synchronous active-high reset
//   clr_i      : force the count to 0 on the next edge
//   run_i      : the next cycle is inside a frame (gates the strobe)
//   tc_o       : registered terminal-count strobe (count == DIV-1 while running)
module bit_timer #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic run_i,
  output logic tc_o
);

  localparam int unsigned    CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tc_q,  tc_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
    // Strobe is precomputed from the next count so it lines up with it.
    tc_d = run_i && (cnt_d == LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Frame sequencer: takes parallel words over valid/ready and emits each as a
// serial frame (start, data LSB first, optional even parity, stop) with a
// per-bit sample strobe for a downstream shift register.
//   clk, reset  : clock, synchronous active-high reset
//   valid_i     : upstream word valid
//   data_i      : parallel word, captured on handshake only
//   ready_o     : idle, can accept a word
//   x_o         : serial line
//   shift_en_o  : strobe on the last cycle of each bit period
//   busy_o      : frame in progress
//   done_o      : one-cycle pulse after the stop bit completes
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned DIV       = 1,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  output logic             x_o,
  output logic             shift_en_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned   IW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [IW-1:0]    idx_q,   idx_d;
  logic             x_q,     x_d;
  logic             ready_q, ready_d;
  logic             busy_q;
  logic             done_q,  done_d;
  logic             tc;

  // Counter is held at 0 throughout IDLE so the first start-bit cycle is count 0.
  bit_timer #(
    .DIV (DIV)
  ) u_bit_timer (
    .clk   (clk),
    .reset (reset),
    .clr_i (state_q == IDLE),
    .run_i (state_d != IDLE),
    .tc_o  (tc)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (valid_i && ready_q) begin
          state_d = START;
          data_d  = data_i;
          idx_d   = '0;
        end
      end
      START: begin
        if (tc) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (tc) begin
          if (idx_q == LAST_IDX) begin
            state_d = PARITY_EN ? PARITY : STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tc) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (tc) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);

    // Line level is decoded from next-state values so x_o can be a register.
    unique case (state_d)
      START:   x_d = START_LVL;
      DATA:    x_d = data_d[idx_d];
      PARITY:  x_d = ^data_d;
      STOP:    x_d = STOP_LVL;
      default: x_d = IDLE_LVL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      x_q     <= IDLE_LVL;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      ready_q <= ready_d;
      busy_q  <= ~ready_d;
      done_q  <= done_d;
    end
  end

  assign ready_o    = ready_q;
  assign busy_o     = busy_q;
  assign x_o        = x_q;
  assign done_o     = done_q;
  assign shift_en_o = tc;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
module tb_shift_seq_ctrl;
  import shift_seq_pkg::*;

  localparam int W  = 4;
  localparam int NI = 4;
  localparam int DIVS [NI] = '{1, 3, 1, 2};
  localparam bit PARS [NI] = '{1'b1, 1'b1, 1'b0, 1'b1};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic valid = 1'b0;
  logic [W-1:0] data = '0;
  logic [NI-1:0] rdy, xo, se, bsy, dn;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.WIDTH(4), .DIV(1), .PARITY_EN(1'b1)) dut0 (
    .clk(clk), .reset(reset), .valid_i(valid), .data_i(data), .ready_o(rdy[0]),
    .x_o(xo[0]), .shift_en_o(se[0]), .busy_o(bsy[0]), .done_o(dn[0]));
  shift_seq_ctrl #(.WIDTH(4), .DIV(3), .PARITY_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .valid_i(valid), .data_i(data), .ready_o(rdy[1]),
    .x_o(xo[1]), .shift_en_o(se[1]), .busy_o(bsy[1]), .done_o(dn[1]));
  shift_seq_ctrl #(.WIDTH(4), .DIV(1), .PARITY_EN(1'b0)) dut2 (
    .clk(clk), .reset(reset), .valid_i(valid), .data_i(data), .ready_o(rdy[2]),
    .x_o(xo[2]), .shift_en_o(se[2]), .busy_o(bsy[2]), .done_o(dn[2]));
  shift_seq_ctrl #(.WIDTH(4), .DIV(2), .PARITY_EN(1'b1)) dut3 (
    .clk(clk), .reset(reset), .valid_i(valid), .data_i(data), .ready_o(rdy[3]),
    .x_o(xo[3]), .shift_en_o(se[3]), .busy_o(bsy[3]), .done_o(dn[3]));

  // Expected {ready, x, shift_en, busy, done} from the position inside a frame.
  function automatic logic [4:0] expect_out(bit a, bit d, int r, logic [W-1:0] w,
                                            int div, bit par);
    int b, ph;
    logic xb;
    if (!a) return {1'b1, 1'b0, 1'b0, 1'b0, d};
    b  = r / div;
    ph = r % div;
    if (b == 0)                 xb = 1'b1;
    else if (b <= W)            xb = w[b-1];
    else if (par && b == W + 1) xb = ^w;
    else                        xb = 1'b0;
    return {1'b0, xb, (ph == div - 1), 1'b1, 1'b0};
  endfunction

  logic [4:0] ev [NI];
  logic [4:0] ov [NI];

  // Reference: a frame is "active" for frame_bits*DIV cycles after the
  // handshake; done follows the last cycle; reset aborts everything.
  for (genvar g = 0; g < NI; g++) begin : model
    localparam int FL = int'(frame_bits(W, PARS[g])) * DIVS[g];
    bit act = 1'b0;
    bit mdone = 1'b0;
    int rel = 0;
    logic [W-1:0] mw = '0;
    always @(posedge clk) begin
      if (reset) begin
        act   <= 1'b0;
        mdone <= 1'b0;
      end else if (act) begin
        if (rel == FL - 1) begin
          act   <= 1'b0;
          mdone <= 1'b1;
        end else begin
          rel   <= rel + 1;
          mdone <= 1'b0;
        end
      end else begin
        mdone <= 1'b0;
        if (valid) begin
          act <= 1'b1;
          rel <= 0;
          mw  <= data;
        end
      end
    end
    assign ev[g] = expect_out(act, mdone, rel, mw, DIVS[g], PARS[g]);
    assign ov[g] = {rdy[g], xo[g], se[g], bsy[g], dn[g]};
  end

  task automatic test_reset();
    reset = 1'b1; valid = 1'b0; data = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      n_cmp++;
      if (ov[k] !== 5'b10000) begin
        n_err++;
        $display("FAIL reset_state inst%0d: got %b expected %b", k, ov[k], 5'b10000);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_div1_parity();
    int seq [7] = '{1, 1, 1, 0, 1, 1, 0};
    valid = 1'b1; data = 4'b1011;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      valid = 1'b0;
      for (int k = 0; k < NI; k++) begin
        n_cmp++;
        if (ov[k] !== ev[k]) begin
          n_err++;
          $display("FAIL div1_model inst%0d cyc%0d: got %b expected %b", k, i, ov[k], ev[k]);
        end
      end
      if (i <= 7) begin
        n_cmp++;
        if (xo[0] !== seq[i-1][0] || se[0] !== 1'b1) begin
          n_err++;
          $display("FAIL div1_line cyc%0d: got x=%b se=%b expected x=%0d se=1", i, xo[0], se[0], seq[i-1]);
        end
      end
      if (i == 8) begin
        n_cmp++;
        if (dn[0] !== 1'b1 || rdy[0] !== 1'b1) begin
          n_err++;
          $display("FAIL div1_done cyc8: got done=%b ready=%b expected 1 1", dn[0], rdy[0]);
        end
      end
    end
  endtask

  task automatic test_div3();
    int pulses = 0;
    int busy_cyc = 0;
    valid = 1'b1; data = 4'b0110;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      valid = 1'b0;
      for (int k = 0; k < NI; k++) begin
        n_cmp++;
        if (ov[k] !== ev[k]) begin
          n_err++;
          $display("FAIL div3_model inst%0d cyc%0d: got %b expected %b", k, i, ov[k], ev[k]);
        end
      end
      if (se[1] === 1'b1) pulses++;
      if (bsy[1] === 1'b1) busy_cyc++;
      if (i == 8 || i == 17) begin
        n_cmp++;
        if (xo[1] !== (i == 8)) begin
          n_err++;
          $display("FAIL div3_bit cyc%0d: got %b expected %b", i, xo[1], (i == 8));
        end
      end
    end
    n_cmp++;
    if (pulses != 7 || busy_cyc != 21) begin
      n_err++;
      $display("FAIL div3_counts: got strobes=%0d busy=%0d expected 7 21", pulses, busy_cyc);
    end
  endtask

  task automatic test_no_parity();
    valid = 1'b1; data = 4'b1111;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      valid = 1'b0;
      for (int k = 0; k < NI; k++) begin
        n_cmp++;
        if (ov[k] !== ev[k]) begin
          n_err++;
          $display("FAIL nopar_model inst%0d cyc%0d: got %b expected %b", k, i, ov[k], ev[k]);
        end
      end
      if (i <= 7) begin
        n_cmp++;
        if (xo[2] !== (i <= 5) || dn[2] !== (i == 7)) begin
          n_err++;
          $display("FAIL nopar_line cyc%0d: got x=%b done=%b expected x=%b done=%b",
                   i, xo[2], dn[2], (i <= 5), (i == 7));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    valid = 1'b1; data = 4'hA;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        n_cmp++;
        if (ov[k] !== ev[k]) begin
          n_err++;
          $display("FAIL b2b_model inst%0d cyc%0d: got %b expected %b", k, i, ov[k], ev[k]);
        end
      end
      if (dn[1] === 1'b1) dones++;
      if (i == 22) begin
        n_cmp++;
        if (dn[1] !== 1'b1 || xo[1] !== 1'b0 || rdy[1] !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_gap cyc22: got done=%b x=%b ready=%b expected 1 0 1", dn[1], xo[1], rdy[1]);
        end
      end
      if (i == 23) begin
        n_cmp++;
        if (xo[1] !== 1'b1 || bsy[1] !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_second cyc23: got x=%b busy=%b expected 1 1", xo[1], bsy[1]);
        end
      end
      if (i == 1)  data = 4'h5;
      if (i == 23) valid = 1'b0;
      if (i == 30) begin valid = 1'b1; data = 4'hF; end
      if (i == 31) valid = 1'b0;
    end
    n_cmp++;
    if (dones != 2) begin
      n_err++;
      $display("FAIL b2b_frames: got %0d done pulses expected 2", dones);
    end
  endtask

  task automatic test_reset_midframe();
    valid = 1'b1; data = 4'b1011;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      valid = 1'b0;
      for (int k = 0; k < NI; k++) begin
        n_cmp++;
        if (ov[k] !== ev[k]) begin
          n_err++;
          $display("FAIL rstmid_model inst%0d cyc%0d: got %b expected %b", k, i, ov[k], ev[k]);
        end
      end
      if (i == 7) begin
        n_cmp++;
        if (xo[3] !== 1'b0 || bsy[3] !== 1'b1) begin
          n_err++;
          $display("FAIL rstmid_bit2: got x=%b busy=%b expected 0 1", xo[3], bsy[3]);
        end
        reset = 1'b1;
      end
      if (i == 8) begin
        n_cmp++;
        if (ov[3] !== 5'b10000) begin
          n_err++;
          $display("FAIL rstmid_abort: got %b expected %b", ov[3], 5'b10000);
        end
        reset = 1'b0;
      end
      if (i == 10) begin valid = 1'b1; data = 4'b0110; end
    end
  endtask

  task automatic test_reset_valid();
    reset = 1'b1; valid = 1'b1; data = 4'h9;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      n_cmp++;
      if (ov[k] !== 5'b10000) begin
        n_err++;
        $display("FAIL rstvalid_held inst%0d: got %b expected %b", k, ov[k], 5'b10000);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    valid = 1'b0;
    for (int k = 0; k < NI; k++) begin
      n_cmp++;
      if (bsy[k] !== 1'b1 || xo[k] !== 1'b1) begin
        n_err++;
        $display("FAIL rstvalid_start inst%0d: got busy=%b x=%b expected 1 1", k, bsy[k], xo[k]);
      end
    end
    repeat (25) @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        n_cmp++;
        if (ov[k] !== ev[k]) begin
          n_err++;
          $display("FAIL random_model inst%0d cyc%0d: got %b expected %b", k, i, ov[k], ev[k]);
        end
      end
      valid = ($urandom_range(0, 3) != 0);
      data  = W'($urandom);
      reset = ($urandom_range(0, 39) == 0);
    end
    reset = 1'b0; valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_div1_parity();
    test_div3();
    test_no_parity();
    test_back_to_back();
    test_reset_midframe();
    test_reset_valid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
